// File: rtl/mesh_link_buffer.sv
// mesh_link_buffer
//   Credit-style link buffer for one mesh port. Upstream flits are queued in a
//   small FIFO and presented to the downstream side, oldest first. A packet
//   tracker watches the flits leaving the FIFO and counts whole packets.
//
//   Packet format (as seen on pops):
//     flit 0 : header (any value)
//     flit 1 : size, low CNT_WIDTH bits = number of payload flits that follow
//     flit 2+: payload
//
// Ports
//   clock      in   single clock, rising edge
//   reset      in   asynchronous, active-low
//   rx         in   upstream flit valid
//   data_i     in   upstream flit [FLIT_WIDTH]
//   credit_o   out  space available to upstream
//   tx         out  downstream flit valid (FIFO not empty)
//   data_o     out  FIFO head flit [FLIT_WIDTH], 0 when empty
//   credit_i   in   downstream can accept
//   flit_cnt   out  saturating count of flits delivered downstream [CNT_WIDTH]
//   pkt_cnt    out  saturating count of complete packets delivered [CNT_WIDTH]
//   in_packet  out  packet tracker is not in HDR
//   overflow   out  sticky: a flit arrived while the FIFO was full
//
// Packet tracker states
//   state      | meaning
//   ST_HDR     | waiting for the header flit of the next packet
//   ST_SIZE    | header popped, next pop carries the payload length
//   ST_PAYLOAD | r_remaining payload flits still to be popped
//
// GROUND = 1 marks a link on the mesh border. The enable w_active ties every
// push/pop/status path low, so all state stays at its reset value and the
// storage has no write path left.

module mesh_link_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int GROUND     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  output logic [CNT_WIDTH-1:0]  flit_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  in_packet,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_HDR,
    ST_SIZE,
    ST_PAYLOAD
  } state_t;

  logic                  w_active;
  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_flit_cnt;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;
  logic [CNT_WIDTH-1:0]  r_remaining;
  state_t                r_state;

  logic                  w_full;
  logic                  w_not_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [FLIT_WIDTH-1:0] w_head;
  logic [CNT_WIDTH-1:0]  w_size;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  w_remaining_nxt;
  logic                  w_pkt_done;

  assign w_active    = (GROUND == 0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_not_empty = (r_count != '0);

  // Outputs are gated by reset so they read 0 the moment reset asserts and
  // credit_o rises combinationally as soon as it is released.
  assign credit_o = w_active & reset & ~w_full;
  assign tx       = w_active & reset & w_not_empty;
  assign w_head   = r_mem[r_rd_ptr];
  assign data_o   = tx ? w_head : '0;

  // A flit arriving while full is dropped even if a pop frees a slot on the
  // same edge: the upstream side was told there was no credit.
  assign w_push = w_active & rx & ~w_full;
  assign w_pop  = tx & credit_i;

  assign w_size = CNT_WIDTH'(w_head);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_flit_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_active && rx && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop && (r_flit_cnt != '1)) begin
        r_flit_cnt <= r_flit_cnt + 1'b1;
      end
      if (w_pkt_done && (r_pkt_cnt != '1)) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HDR;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_pkt_done      = 1'b0;
    if (w_pop) begin
      case (r_state)
        ST_HDR: begin
          w_state_nxt = ST_SIZE;
        end
        ST_SIZE: begin
          w_remaining_nxt = w_size;
          if (w_size != '0) begin
            w_state_nxt = ST_PAYLOAD;
          end else begin
            w_state_nxt = ST_HDR;
            w_pkt_done  = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == CNT_WIDTH'(1)) begin
            w_state_nxt = ST_HDR;
            w_pkt_done  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_HDR;
        end
      endcase
    end
  end

  assign flit_cnt  = r_flit_cnt;
  assign pkt_cnt   = r_pkt_cnt;
  assign in_packet = (r_state != ST_HDR);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_mesh_link_buffer.sv
module tb_mesh_link_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b0;
  logic [31:0] data_i = '0;
  logic        credit_i = 1'b0;
  logic        credit_o, tx, in_packet, overflow;
  logic [31:0] data_o;
  logic [15:0] flit_cnt, pkt_cnt;

  logic        g_rx = 1'b0;
  logic [31:0] g_data_i = '0;
  logic        g_credit_i = 1'b0;
  logic        g_credit_o, g_tx, g_in_packet, g_overflow;
  logic [31:0] g_data_o;
  logic [15:0] g_flit_cnt, g_pkt_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mesh_link_buffer #(.FLIT_WIDTH(32), .DEPTH(4), .CNT_WIDTH(16), .GROUND(0)) dut (
    .clock(clock), .reset(reset), .rx(rx), .data_i(data_i), .credit_o(credit_o),
    .tx(tx), .data_o(data_o), .credit_i(credit_i), .flit_cnt(flit_cnt),
    .pkt_cnt(pkt_cnt), .in_packet(in_packet), .overflow(overflow)
  );

  mesh_link_buffer #(.FLIT_WIDTH(32), .DEPTH(4), .CNT_WIDTH(16), .GROUND(1)) gnd (
    .clock(clock), .reset(reset), .rx(g_rx), .data_i(g_data_i), .credit_o(g_credit_o),
    .tx(g_tx), .data_o(g_data_o), .credit_i(g_credit_i), .flit_cnt(g_flit_cnt),
    .pkt_cnt(g_pkt_cnt), .in_packet(g_in_packet), .overflow(g_overflow)
  );

  typedef struct {
    bit          rst;
    bit          rx;
    logic [31:0] din;
    bit          ci;
    bit          tx;
    logic [31:0] dout;
    bit          cr;
    logic [15:0] fc;
    logic [15:0] pc;
    bit          ip;
    bit          ov;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rx = 1'b0;
    credit_i = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit r, input logic [31:0] d, input bit c);
    rx = r;
    data_i = d;
    credit_i = c;
  endtask

  int   sent, got, cyc;
  logic [31:0] q[$];
  logic [31:0] expd;

  initial begin
    // fill / drain
    vecs[0]  = '{1, 1, 32'hA0, 0,   1, 32'hA0, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 32'hA1, 0,   1, 32'hA0, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 32'hA2, 0,   1, 32'hA0, 1, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 32'hA3, 0,   1, 32'hA0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 32'h0,  1,   1, 32'hA1, 1, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 32'h0,  1,   1, 32'hA2, 1, 2, 0, 1, 0};
    vecs[6]  = '{0, 0, 32'h0,  1,   1, 32'hA3, 1, 3, 0, 1, 0};
    vecs[7]  = '{0, 0, 32'h0,  1,   0, 32'h0,  1, 4, 0, 1, 0};
    // overflow with same-cycle pop
    vecs[8]  = '{1, 1, 32'hB0, 0,   1, 32'hB0, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 32'hB1, 0,   1, 32'hB0, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 1, 32'hB2, 0,   1, 32'hB0, 1, 0, 0, 0, 0};
    vecs[11] = '{0, 1, 32'hB3, 0,   1, 32'hB0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 1, 32'hFF, 1,   1, 32'hB1, 1, 1, 0, 1, 1};
    vecs[13] = '{0, 0, 32'h0,  1,   1, 32'hB2, 1, 2, 0, 1, 1};
    vecs[14] = '{0, 0, 32'h0,  1,   1, 32'hB3, 1, 3, 0, 1, 1};
    vecs[15] = '{0, 0, 32'h0,  1,   0, 32'h0,  1, 4, 0, 1, 1};
    // packet stream: hdr, size 2, P0, P1, hdr, size 0
    vecs[16] = '{1, 1, 32'h0101, 1, 1, 32'h0101, 1, 0, 0, 0, 0};
    vecs[17] = '{0, 1, 32'h0002, 1, 1, 32'h0002, 1, 1, 0, 1, 0};
    vecs[18] = '{0, 1, 32'h00C0, 1, 1, 32'h00C0, 1, 2, 0, 1, 0};
    vecs[19] = '{0, 1, 32'h00C1, 1, 1, 32'h00C1, 1, 3, 0, 1, 0};
    vecs[20] = '{0, 1, 32'h0100, 1, 1, 32'h0100, 1, 4, 1, 0, 0};
    vecs[21] = '{0, 1, 32'h0000, 1, 1, 32'h0000, 1, 5, 1, 1, 0};
    vecs[22] = '{0, 0, 32'h0,    1, 0, 32'h0,    1, 6, 2, 0, 0};

    // reset state, both while held and just after release
    #12;
    chk("rst_held_credit", {31'b0, credit_o}, 32'd0);
    chk("rst_held_tx", {31'b0, tx}, 32'd0);
    chk("rst_held_data", data_o, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_rel_credit", {31'b0, credit_o}, 32'd1);
    chk("rst_rel_cnts", {flit_cnt, pkt_cnt}, 32'd0);
    chk("rst_rel_flags", {29'b0, tx, in_packet, overflow}, 32'd0);
    step();

    for (int i = 0; i < 23; i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].rx, vecs[i].din, vecs[i].ci);
      step();
      chk($sformatf("v%0d_tx", i), {31'b0, tx}, {31'b0, vecs[i].tx});
      chk($sformatf("v%0d_data", i), data_o, vecs[i].dout);
      chk($sformatf("v%0d_credit", i), {31'b0, credit_o}, {31'b0, vecs[i].cr});
      chk($sformatf("v%0d_flit_cnt", i), {16'b0, flit_cnt}, {16'b0, vecs[i].fc});
      chk($sformatf("v%0d_pkt_cnt", i), {16'b0, pkt_cnt}, {16'b0, vecs[i].pc});
      chk($sformatf("v%0d_in_packet", i), {31'b0, in_packet}, {31'b0, vecs[i].ip});
      chk($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].ov});
    end

    // wrap: 13 flits, credit_i alternating, queue model for ordering
    do_reset();
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 13 && cyc < 200) begin
      rx = (sent < 13) && credit_o;
      data_i = 32'h100 + sent;
      credit_i = cyc[0];
      @(negedge clock);
      if (tx && credit_i) begin
        expd = q.pop_front();
        chk($sformatf("wrap_data%0d", got), data_o, expd);
        got++;
      end
      if (rx && credit_o) begin
        q.push_back(data_i);
        sent++;
      end
      step();
      cyc++;
    end
    chk("wrap_all_received", got, 32'd13);
    chk("wrap_no_overflow", {31'b0, overflow}, 32'd0);
    chk("wrap_flit_cnt", {16'b0, flit_cnt}, 32'd13);

    // reset in the middle of a size-5 packet
    do_reset();
    drive(1, 32'h0, 0); step();
    drive(1, 32'h5, 0); step();
    drive(1, 32'hE0, 0); step();
    drive(0, 32'h0, 1); step();
    drive(0, 32'h0, 1); step();
    chk("midpkt_in_packet", {31'b0, in_packet}, 32'd1);
    chk("midpkt_flit_cnt", {16'b0, flit_cnt}, 32'd2);
    chk("midpkt_head", data_o, 32'hE0);
    credit_i = 1'b0;
    reset = 1'b0;
    #1;
    chk("midpkt_rst_out", {credit_o, tx, in_packet, overflow}, 32'd0);
    chk("midpkt_rst_data", data_o, 32'd0);
    chk("midpkt_rst_cnts", {flit_cnt, pkt_cnt}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("midpkt_rel_credit", {31'b0, credit_o}, 32'd1);
    chk("midpkt_rel_tx", {31'b0, tx}, 32'd0);
    step();
    drive(1, 32'h7, 1); step();
    drive(1, 32'h1, 1); step();
    drive(1, 32'h33, 1); step();
    drive(0, 32'h0, 1); step();
    chk("newpkt_pkt_cnt", {16'b0, pkt_cnt}, 32'd1);
    chk("newpkt_flit_cnt", {16'b0, flit_cnt}, 32'd3);
    chk("newpkt_in_packet", {31'b0, in_packet}, 32'd0);
    chk("newpkt_tx", {31'b0, tx}, 32'd0);

    // grounded link ignores everything
    g_credit_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      g_rx = 1'b1;
      g_data_i = $urandom();
      @(negedge clock);
      chk($sformatf("gnd%0d_ctl", i), {g_credit_o, g_tx, g_in_packet, g_overflow}, 32'd0);
      chk($sformatf("gnd%0d_data", i), g_data_o, 32'd0);
      chk($sformatf("gnd%0d_cnts", i), {g_flit_cnt, g_pkt_cnt}, 32'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mesh_link_buffer.md
MESH_LINK_BUFFER -- requirements
Module: mesh_link_buffer

Interface
REQ-001 The block SHALL have parameter FLIT_WIDTH, default 32, meaning flit width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO depth in flits; power of two, >= 2.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, meaning width of the statistics counters.
REQ-004 The block SHALL have parameter GROUND, default 0, meaning 1 = border-grounded link, 0 = active link.
REQ-005 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have port rx, input, 1 bit, meaning upstream flit valid.
REQ-008 The block SHALL have port data_i, input, FLIT_WIDTH bits, meaning upstream flit.
REQ-009 The block SHALL have port credit_o, output, 1 bit, meaning space available to upstream.
REQ-010 The block SHALL have port tx, output, 1 bit, meaning downstream flit valid.
REQ-011 The block SHALL have port data_o, output, FLIT_WIDTH bits, meaning downstream flit (FIFO head).
REQ-012 The block SHALL have port credit_i, input, 1 bit, meaning downstream can accept.
REQ-013 The block SHALL have port flit_cnt, output, CNT_WIDTH bits, meaning flits delivered downstream.
REQ-014 The block SHALL have port pkt_cnt, output, CNT_WIDTH bits, meaning complete packets delivered downstream.
REQ-015 The block SHALL have port in_packet, output, 1 bit, high while the packet tracker is not in state HDR.
REQ-016 The block SHALL have port overflow, output, 1 bit, a sticky flag set when a flit arrives while full.

Function
REQ-017 The block SHALL drive credit_o = 1 exactly when occupancy < DEPTH and reset is deasserted.
REQ-018 The block SHALL push data_i into the FIFO on a clock edge where rx = 1 and occupancy < DEPTH.
REQ-019 When rx = 1 and occupancy = DEPTH, the block SHALL drop the flit and set overflow; this holds even with a same-cycle pop.
REQ-020 The block SHALL drive tx = 1 exactly when occupancy > 0, and data_o SHALL equal the oldest stored flit.
REQ-021 The block SHALL pop on a clock edge where tx = 1 and credit_i = 1.
REQ-022 On a simultaneous push and pop when not full, occupancy SHALL stay unchanged and both operations SHALL take effect.
REQ-023 Latency: a flit pushed into an empty FIFO at edge N SHALL appear on data_o with tx = 1 after edge N (one cycle).
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; the occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-025 The packet tracker SHALL advance on pops only, with states HDR, SIZE and PAYLOAD.
REQ-026 HDR->SIZE: the tracker SHALL take this transition on any pop.
REQ-027 SIZE: on a pop, the tracker SHALL load remaining = popped flit value (low CNT_WIDTH bits); it SHALL go to PAYLOAD if the value is nonzero, else to HDR with pkt_cnt incremented.
REQ-028 PAYLOAD: each pop SHALL decrement remaining; the pop with remaining = 1 SHALL return the tracker to HDR and increment pkt_cnt.
REQ-029 flit_cnt SHALL increment by 1 on every pop.
REQ-030 flit_cnt and pkt_cnt SHALL saturate at all-ones and never wrap.
REQ-031 With GROUND = 1, credit_o, tx, data_o, the counters, in_packet and overflow SHALL be held at 0 and rx SHALL be ignored; no storage is required.

Reset
REQ-032 When reset = 0, the block SHALL immediately clear pointers, occupancy, the tracker (HDR), remaining, flit_cnt, pkt_cnt and overflow.
REQ-033 While reset = 0, tx = 0, data_o = 0 and credit_o = 0; credit_o SHALL rise combinationally on deassertion.
REQ-034 Reset asserted mid-packet or mid-transfer SHALL discard stored flits and any partial packet, with no count increment.

Verification
REQ-035 Fill/drain: credit_i = 0; push 4 flits 0xA0..0xA3 (DEPTH = 4). Required: credit_o = 0 after the 4th push. Then credit_i = 1 for 4 cycles. Required: data_o sequence A0, A1, A2, A3; flit_cnt = 4; credit_o = 1.
REQ-036 Overflow: with the FIFO full, assert rx with 0xFF and credit_i = 1 in the same cycle. Required: the flit is dropped, overflow = 1 and stays 1, and the next data_o values come from the original contents.
REQ-037 Packet count: stream flits 0x0101, 0x0002, P0, P1, 0x0100, 0x0000 with credit_i = 1. Required: pkt_cnt = 2, flit_cnt = 6, in_packet = 0 at the end.
REQ-038 Wrap: run 3*DEPTH+1 flits with alternating credit_i. Required: order preserved across pointer wrap and no overflow.
REQ-039 Reset mid-packet: assert reset after the SIZE flit of a packet of size 5. Required: all outputs read 0 at once; after release, a new 3-flit packet (header, size 1, one payload) gives pkt_cnt = 1.
REQ-040 GROUND = 1: drive rx = 1 with random data for 20 cycles. Required: credit_o = tx = 0, data_o = 0, all counters 0, overflow = 0.
